// File: rtl/lyr_pkg.sv
// Shared definitions for the dense-layer sequencers of the VAE forward path.
// Latency: n/a (constants only).
// Backpressure: n/a.
package lyr_pkg;

  // Datapath width of activations, weights, biases and MAC results.
  localparam int DW = 16;

  // Field offsets inside one 48-bit weight word {b, w2, w1}.
  localparam int W1_LSB = 0;
  localparam int W2_LSB = 16;
  localparam int B_LSB  = 32;
  localparam int WW     = 48;

  // Sequencer states, kept as plain constants for older consumers.
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_FETCH = 3'd1;
  localparam state_t S_WAIT  = 3'd2;
  localparam state_t S_MAC   = 3'd3;
  localparam state_t S_OUT   = 3'd4;
  localparam state_t S_DONE  = 3'd5;

endpackage

// File: rtl/lyr_relu.sv
// Combinational ReLU on a signed DW-bit value; EN=0 turns it into a wire.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
// Ports: x = input value, y = max(x, 0) when EN=1, else x.
module lyr_relu
  import lyr_pkg::*;
#(
  parameter int EN = 1
) (
  input  logic [DW-1:0] x,
  output logic [DW-1:0] y
);

  // Negative values clamp to zero; positive values, including 0x7FFF, pass.
  assign y = ((EN != 0) && x[DW-1]) ? '0 : x;

endmodule

// File: rtl/lyr2_mac_seq.sv
// Time-shares one external 2-input MAC across N_NEURON neurons of a dense layer.
// Latency: neuron k valid 4+4k cycles after start (ready high); done at 4*N+1.
// Backpressure: holds out_valid/out_data/out_idx while out_ready=0; no fetch issued.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   start, d1_in, d2_in  layer request and its two inputs (latched on accept)
//   busy, done           activity flag, one-cycle completion pulse
//   w_rd_en/w_addr/w_rdata  synchronous weight memory, 1-cycle read latency
//   mac_*                registered MAC operands and combinational result
//   out_valid/out_ready/out_data/out_idx  result stream
module lyr2_mac_seq
  import lyr_pkg::*;
#(
  parameter int N_NEURON  = 4,
  parameter int AW        = 2,
  parameter int BASE_ADDR = 0,
  parameter int RELU_EN   = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [15:0]   d1_in,
  input  logic [15:0]   d2_in,
  output logic          busy,
  output logic          done,
  output logic          w_rd_en,
  output logic [AW-1:0] w_addr,
  input  logic [47:0]   w_rdata,
  output logic [15:0]   mac_d1,
  output logic [15:0]   mac_d2,
  output logic [15:0]   mac_w1,
  output logic [15:0]   mac_w2,
  output logic [15:0]   mac_b,
  input  logic [15:0]   mac_res,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [15:0]   out_data,
  output logic [AW-1:0] out_idx
);

  localparam logic [AW-1:0] LAST = AW'(N_NEURON - 1);
  localparam logic [AW-1:0] BASE = AW'(BASE_ADDR);
  localparam logic [AW-1:0] ONE  = AW'(1);

  state_t        state;
  logic [AW-1:0] idx;
  logic [AW-1:0] idx_nxt;
  logic [15:0]   act;

  assign idx_nxt = idx + ONE;

  lyr_relu #(.EN(RELU_EN)) u_relu (
    .x (mac_res),
    .y (act)
  );

  // w_rd_en, busy and done are registered on the transition into the state
  // they belong to, so they line up exactly with FETCH, non-IDLE and DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      w_rd_en   <= 1'b0;
      w_addr    <= '0;
      mac_d1    <= '0;
      mac_d2    <= '0;
      mac_w1    <= '0;
      mac_w2    <= '0;
      mac_b     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mac_d1  <= d1_in;
            mac_d2  <= d2_in;
            idx     <= '0;
            w_rd_en <= 1'b1;
            w_addr  <= BASE;
            busy    <= 1'b1;
            state   <= S_FETCH;
          end
        end
        S_FETCH: begin
          w_rd_en <= 1'b0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          // Read data is valid now, one cycle after the strobe.
          mac_w1 <= w_rdata[W1_LSB +: DW];
          mac_w2 <= w_rdata[W2_LSB +: DW];
          mac_b  <= w_rdata[B_LSB  +: DW];
          state  <= S_MAC;
        end
        S_MAC: begin
          out_data  <= act;
          out_idx   <= idx;
          out_valid <= 1'b1;
          state     <= S_OUT;
        end
        S_OUT: begin
          // out_valid is always high here, so out_ready alone is the handshake.
          if (out_ready) begin
            out_valid <= 1'b0;
            if (idx == LAST) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              idx     <= idx_nxt;
              w_rd_en <= 1'b1;
              w_addr  <= BASE + idx_nxt;
              state   <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy      <= 1'b0;
          w_rd_en   <= 1'b0;
          out_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lyr2_mac_seq.sv
// Bench for lyr2_mac_seq: a 4-neuron ReLU instance and a 1-neuron pass-through
// instance at BASE_ADDR=3, both fed by one weight memory and an ideal MAC.
// Expectations come from a transaction-level schedule and arithmetic model.
module tb_lyr2_mac_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, start_b, out_ready;
  logic [15:0] d1_in, d2_in;
  logic [47:0] mem [4];

  logic        busy, done, w_rd_en, out_valid;
  logic [1:0]  w_addr, out_idx;
  logic [47:0] w_rdata = '0;
  logic [15:0] mac_d1, mac_d2, mac_w1, mac_w2, mac_b, mac_res, out_data;

  logic        busy_b, done_b, w_rd_en_b, out_valid_b;
  logic [1:0]  w_addr_b, out_idx_b;
  logic [47:0] w_rdata_b = '0;
  logic [15:0] mac_d1_b, mac_d2_b, mac_w1_b, mac_w2_b, mac_b_b, mac_res_b, out_data_b;
  logic        out_ready_b = 1'b1;

  lyr2_mac_seq #(.N_NEURON(4), .AW(2), .BASE_ADDR(0), .RELU_EN(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .d1_in(d1_in), .d2_in(d2_in),
    .busy(busy), .done(done), .w_rd_en(w_rd_en), .w_addr(w_addr), .w_rdata(w_rdata),
    .mac_d1(mac_d1), .mac_d2(mac_d2), .mac_w1(mac_w1), .mac_w2(mac_w2), .mac_b(mac_b),
    .mac_res(mac_res), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx)
  );

  lyr2_mac_seq #(.N_NEURON(1), .AW(2), .BASE_ADDR(3), .RELU_EN(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .d1_in(d1_in), .d2_in(d2_in),
    .busy(busy_b), .done(done_b), .w_rd_en(w_rd_en_b), .w_addr(w_addr_b), .w_rdata(w_rdata_b),
    .mac_d1(mac_d1_b), .mac_d2(mac_d2_b), .mac_w1(mac_w1_b), .mac_w2(mac_w2_b), .mac_b(mac_b_b),
    .mac_res(mac_res_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_data(out_data_b), .out_idx(out_idx_b)
  );

  // Environment: synchronous weight memory and ideal wrapping MAC.
  always @(posedge clk) begin
    if (w_rd_en)   w_rdata   <= mem[w_addr];
    if (w_rd_en_b) w_rdata_b <= mem[w_addr_b];
  end
  assign mac_res   = mac_d1 * mac_w1 + mac_d2 * mac_w2 + mac_b;
  assign mac_res_b = mac_d1_b * mac_w1_b + mac_d2_b * mac_w2_b + mac_b_b;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference arithmetic: d1*w1 + d2*w2 + b modulo 2^16, then optional ReLU.
  function automatic logic [15:0] ref_mac(input logic [15:0] a1, input logic [15:0] a2,
                                          input logic [47:0] w);
    longint s;
    s = longint'(a1) * longint'(w[15:0]) + longint'(a2) * longint'(w[31:16])
        + longint'(w[47:32]);
    return s[15:0];
  endfunction

  function automatic logic [15:0] ref_f(input logic [15:0] x, input bit relu);
    if (relu && $signed(x) < 0) return 16'h0000;
    return x;
  endfunction

  task automatic check_zero(input string who);
    chk({who, " busy"},    busy,      0);
    chk({who, " done"},    done,      0);
    chk({who, " rd_en"},   w_rd_en,   0);
    chk({who, " w_addr"},  w_addr,    0);
    chk({who, " mac_d1"},  mac_d1,    0);
    chk({who, " mac_d2"},  mac_d2,    0);
    chk({who, " mac_w1"},  mac_w1,    0);
    chk({who, " mac_w2"},  mac_w2,    0);
    chk({who, " mac_b"},   mac_b,     0);
    chk({who, " valid"},   out_valid, 0);
    chk({who, " data"},    out_data,  0);
    chk({who, " idx"},     out_idx,   0);
  endtask

  // One layer on the 4-neuron instance. Called and returns at a negedge.
  // Edge e is the e-th rising edge after the start-sample edge; the checks
  // made before edge e are the values that edge will see.
  task automatic run_layer(input logic [15:0] a1, input logic [15:0] a2,
                           input bit rnd_ready, input int stall_k, input int stall_len,
                           input int busy_start_e, input bit start_in_done, input int rst_e);
    int k, p, stalled, last_acc;
    bit fin;
    start = 1'b1; d1_in = a1; d2_in = a2; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0; d1_in = 16'($urandom); d2_in = 16'($urandom);
    k = 0; p = 4; stalled = 0; last_acc = -10; fin = 1'b0;
    for (int e = 1; e < 300 && !fin; e++) begin
      start = (e == busy_start_e) || (start_in_done && e == last_acc + 1);
      if (start) begin d1_in = 16'($urandom); d2_in = 16'($urandom); end
      if (k < 4 && e >= p && k == stall_k && stalled < stall_len) begin
        out_ready = 1'b0; stalled++;
      end else if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
      else out_ready = 1'b1;

      chk($sformatf("busy e%0d", e),  busy,      (k < 4) || (e == last_acc + 1));
      chk($sformatf("done e%0d", e),  done,      (k == 4) && (e == last_acc + 1));
      chk($sformatf("rd_en e%0d", e), w_rd_en,   (k < 4) && (e == p - 3));
      chk($sformatf("valid e%0d", e), out_valid, (k < 4) && (e >= p));
      if (k < 4 && e == p - 3) chk($sformatf("w_addr n%0d", k), w_addr, k);
      if (k < 4 && e == p - 1) begin
        chk($sformatf("mac_d1 n%0d", k), mac_d1, a1);
        chk($sformatf("mac_d2 n%0d", k), mac_d2, a2);
        chk($sformatf("mac_w1 n%0d", k), mac_w1, mem[k][15:0]);
        chk($sformatf("mac_w2 n%0d", k), mac_w2, mem[k][31:16]);
        chk($sformatf("mac_b n%0d", k),  mac_b,  mem[k][47:32]);
      end
      if (k < 4 && e >= p) begin
        chk($sformatf("data n%0d e%0d", k, e), out_data, ref_f(ref_mac(a1, a2, mem[k]), 1'b1));
        chk($sformatf("idx n%0d e%0d", k, e),  out_idx, k);
      end

      if (e == rst_e) begin
        start = 1'b0; rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        check_zero("midrst");
        return;
      end

      if (k < 4 && e >= p && out_ready) begin
        last_acc = e; k++; p = e + 4;
      end
      if (k == 4 && e == last_acc + 2) begin
        chk("relatch d1", mac_d1, a1);
        chk("relatch d2", mac_d2, a2);
        fin = 1'b1;
      end else begin
        @(posedge clk); @(negedge clk);
      end
    end
    start = 1'b0;
    chk("layer timeout", fin, 1'b1);
  endtask

  // One run of the single-neuron pass-through instance (reads mem[3]).
  task automatic run_b(input logic [15:0] a1, input logic [15:0] a2);
    logic [15:0] exp;
    exp = ref_mac(a1, a2, mem[3]);
    start_b = 1'b1; d1_in = a1; d2_in = a2;
    @(posedge clk); @(negedge clk);
    start_b = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      chk($sformatf("b busy e%0d", e),  busy_b,      e <= 5);
      chk($sformatf("b rd_en e%0d", e), w_rd_en_b,   e == 1);
      chk($sformatf("b valid e%0d", e), out_valid_b, e == 4);
      chk($sformatf("b done e%0d", e),  done_b,      e == 5);
      if (e == 1) chk("b w_addr", w_addr_b, 2'd3);
      if (e == 3) begin
        chk("b mac_d1", mac_d1_b, a1);
        chk("b mac_w1", mac_w1_b, mem[3][15:0]);
        chk("b mac_b",  mac_b_b,  mem[3][47:32]);
      end
      if (e == 4) begin
        chk("b data", out_data_b, exp);
        chk("b idx",  out_idx_b,  0);
      end
      if (e < 6) begin @(posedge clk); @(negedge clk); end
    end
  endtask

  task automatic rand_mem();
    for (int i = 0; i < 4; i++) mem[i] = {16'($urandom), 16'($urandom), 16'($urandom)};
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start_b = 1'b0; out_ready = 1'b1;
    d1_in = '0; d2_in = '0;
    for (int i = 0; i < 4; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    chk("reset b busy",  busy_b,      0);
    chk("reset b valid", out_valid_b, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single neuron, pass-through build, BASE_ADDR offset.
    mem[3] = {16'h0010, 16'h0003, 16'h0002};
    run_b(16'h0100, 16'h0200);
    mem[3] = {16'h0000, 16'h0000, 16'h8001};
    run_b(16'h0001, 16'h0000);
    mem[3] = {16'h0000, 16'h0000, 16'h7FFF};
    run_b(16'h0001, 16'h0000);

    // ReLU boundaries on the 4-neuron build, steady ready.
    mem[0] = {16'h0000, 16'h0000, 16'h8001};
    mem[1] = {16'h0000, 16'h0000, 16'h7FFF};
    mem[2] = {16'h0010, 16'h0003, 16'h0002};
    mem[3] = {16'hFFFF, 16'h0000, 16'h0000};
    run_layer(16'h0001, 16'h0000, 1'b0, -1, 0, -1, 1'b0, -1);

    // Distinct weights, 5-cycle stall on neuron 1, start pulses in WAIT and DONE.
    rand_mem();
    run_layer(16'($urandom), 16'($urandom), 1'b0, 1, 5, 2, 1'b1, -1);

    // Reset in WAIT of neuron 2, then a clean restart from neuron 0.
    rand_mem();
    run_layer(16'($urandom), 16'($urandom), 1'b0, -1, 0, -1, 1'b0, 10);
    run_layer(16'($urandom), 16'($urandom), 1'b0, -1, 0, -1, 1'b0, -1);

    // Random weights, inputs and downstream readiness.
    repeat (6) begin
      rand_mem();
      run_layer(16'($urandom), 16'($urandom), 1'b1, -1, 0, -1, 1'b0, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
